// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order FIFO of core stores draining to a slow
// memory over a req/ack port, with youngest-match forwarding to core loads.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     strobe,
  input  logic                     mem_rw,
  input  logic [31:0]              d_addr,
  input  logic [31:0]              d_wdata,
  output logic [31:0]              d_rdata,
  output logic [31:0]              rd_addr,
  input  logic [31:0]              rd_data,
  output logic                     wr_req,
  output logic [31:0]              wr_addr,
  output logic [31:0]              wr_data,
  input  logic                     wr_ack,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [LW-1:0] level_q;
  logic          ovf_q;
  logic          push, pop, drop;
  logic [PW-1:0] fwd_idx;

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign level    = level_q;
  assign overflow = ovf_q;
  assign wr_req   = !empty;
  assign wr_addr  = addr_q[head];
  assign wr_data  = data_q[head];
  assign rd_addr  = d_addr;

  // A pop in the same cycle frees the slot, so a full buffer still accepts.
  assign pop  = wr_req & wr_ack;
  assign push = strobe & mem_rw & (!full | pop);
  assign drop = strobe & mem_rw & full & !pop;

  // Entry storage; validity is tracked by level, so no reset needed here.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      addr_q[tail] <= d_addr;
      data_q[tail] <= d_wdata;
    end
  end

  // Pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
      if (drop) ovf_q <= 1'b1;
    end
  end

  // Load forwarding: walk oldest to youngest over valid entries, last match wins.
  always_comb begin
    d_rdata = rd_data;
    fwd_idx = head;
    if (strobe && !mem_rw) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head + PW'(i);
        if (i < int'(level_q) && addr_q[fwd_idx] == d_addr)
          d_rdata = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed scenarios plus randomized traffic against a queue-based model.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset, strobe, mem_rw, wr_ack;
  logic [31:0]            d_addr, d_wdata, rd_data;
  logic [31:0]            d_rdata, rd_addr, wr_addr, wr_data;
  logic                   wr_req, empty, full, overflow;
  logic [$clog2(DEPTH):0] level;

  int passed = 0, total = 0, fails = 0;
  logic [63:0] q[$];
  bit          ovf_m;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .mem_rw(mem_rw),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_req(wr_req),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .empty(empty), .full(full), .level(level), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic rw, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input logic ack, input logic rst);
    strobe = s; mem_rw = rw; d_addr = a; d_wdata = wd;
    rd_data = rd; wr_ack = ack; reset = rst;
    #1;
  endtask

  // Expected combinational outputs from the model's current contents.
  task automatic model_check();
    logic [31:0] exp_rd;
    exp_rd = rd_data;
    if (strobe && !mem_rw)
      foreach (q[i]) if (q[i][63:32] == d_addr) exp_rd = q[i][31:0];
    chk("d_rdata", d_rdata, exp_rd);
    chk("rd_addr", rd_addr, d_addr);
    chk("wr_req", 32'(wr_req), 32'(q.size() != 0));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    if (q.size() != 0) begin
      chk("wr_addr", wr_addr, q[0][63:32]);
      chk("wr_data", wr_data, q[0][31:0]);
    end
  endtask

  task automatic model_update();
    if (reset) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      if (q.size() != 0 && wr_ack) void'(q.pop_front());
      if (strobe && mem_rw) begin
        if (q.size() < DEPTH) q.push_back({d_addr, d_wdata});
        else ovf_m = 1'b1;
      end
    end
  endtask

  task automatic step(input logic s, input logic rw, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input logic ack, input logic rst);
    drive(s, rw, a, wd, rd, ack, rst);
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 1);
    @(posedge clk);
    @(negedge clk);
    q.delete();
    ovf_m = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // 1: single store, ack three cycles after push
    step(1, 1, 32'h100, 32'hDEAD, 0, 0, 0);
    chk("t1_req", 32'(wr_req), 1);
    chk("t1_addr", wr_addr, 32'h100);
    chk("t1_data", wr_data, 32'hDEAD);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t1_empty", 32'(empty), 1);

    // 2: forwarding picks the youngest match, misses fall through to memory
    step(1, 1, 32'h10, 32'h1, 0, 0, 0);
    step(1, 1, 32'h10, 32'h2, 0, 0, 0);
    step(1, 1, 32'h20, 32'h3, 0, 0, 0);
    drive(1, 0, 32'h10, 0, 32'h77, 0, 0);
    chk("t2_fwd", d_rdata, 32'h2);
    step(1, 0, 32'h10, 0, 32'h77, 0, 0);
    drive(1, 0, 32'h30, 0, 32'h77, 0, 0);
    chk("t2_miss", d_rdata, 32'h77);
    step(1, 0, 32'h30, 0, 32'h77, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
    chk("t2_empty", 32'(empty), 1);

    // 3: overflow on a fifth store, drain order is the first four
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 32'h200 + 32'(i), 32'hA0 + 32'(i), 0, 0, 0);
      if (i == 3) chk("t3_full", 32'(full), 1);
    end
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_level", 32'(level), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", wr_addr, 32'h200 + 32'(i));
      step(0, 0, 0, 0, 0, 1, 0);
    end
    chk("t3_ovf_sticky", 32'(overflow), 1);

    // 4: full buffer, store coincident with ack
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h300 + 32'(i), 32'h1000 + 32'(i), 0, 0, 0);
    step(1, 1, 32'h3F0, 32'h10F0, 0, 1, 0);
    chk("t4_level", 32'(level), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_next", wr_addr, 32'h301);

    // 5: load of the head address while it is being acked
    drive(1, 0, 32'h301, 0, 32'h55, 1, 0);
    chk("t5_fwd_pop", d_rdata, 32'h1001);
    step(1, 0, 32'h301, 0, 32'h55, 1, 0);
    chk("t5_level", 32'(level), 3);

    // 6: reset with entries pending, then restart from pointer 0
    chk("t6_req_pre", 32'(wr_req), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("t6_req", 32'(wr_req), 0);
    chk("t6_empty", 32'(empty), 1);
    chk("t6_ovf", 32'(overflow), 0);
    step(1, 1, 32'h400, 32'hBEEF, 0, 0, 0);
    chk("t6_addr", wr_addr, 32'h400);
    chk("t6_data", wr_data, 32'hBEEF);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t6_drained", 32'(empty), 1);

    // randomized traffic over a small address set to exercise forwarding
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           32'($urandom_range(0, 7)) << 2, $urandom, $urandom,
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 59) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
